hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Single controller that produces the per-stage stall/flush control (hazard_data_t) consumed by the f_d/d_e/e_m/m_w pipeline registers.
- Also produces the PC hold and the execute-stage forwarding selects.
- Tracks in-flight instruction-memory and data-memory handshakes with small FSMs. This lets multi-cycle memories, load-use hazards, and branch/jump redirects be resolved in one place.
- Sits beside the 5-stage MIPS datapath (add/sub/and/or/slt/addi/lw/sw/j/beq).

Parameters:
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- imem_req  in  1  fetch stage has a request outstanding or issuing.
- imem_data_ok  in  1  instruction word valid this cycle.
- dmem_req  in  1  memory stage holds lw/sw and is issuing.
- dmem_data_ok  in  1  data access completes this cycle.
- d_rs, d_rt  in  5 each  decode-stage source registers (creg_addr_t).
- d_uses_rs, d_uses_rt  in  1 each  decode instruction actually reads rs/rt.
- d_jump  in  1  decode holds j.
- e_rs, e_rt  in  5 each  execute-stage sources.
- e_dst  in  5  execute destination.
- e_reg_write, e_mem_to_reg  in  1 each  execute control bits.
- e_branch_taken  in  1  beq resolved taken in execute.
- m_dst  in  5  memory-stage destination.
- m_reg_write, m_mem_to_reg  in  1 each  memory-stage control bits.
- w_dst  in  5  writeback destination.
- w_reg_write  in  1  writeback writes the register file.
- hazard  out  hazard_data_t  item X controls the register at the output of stage X. stall = hold; flush = load bubble.
- pc_stall  out  1  PC holds.
- pc_redirect  out  1  PC takes the branch/jump target this cycle.
- fwd_rs, fwd_rt  out  2 each  fwd_sel_t: 00 regfile, 01 memory alu_result, 10 writeback value.
- imem_discard  out  1  returning instruction word must be dropped.
- stall_cycles, flush_events  out  CNT_W each  performance counters.

Behaviour:
- Reset: FSMs go to F_IDLE/M_IDLE and counters clear. While resetn = 0, every output is forced to 0.
- Never assert stall and flush on the same hazard item.

M FSM:
- M_IDLE to M_WAIT when dmem_req & !dmem_data_ok.
- M_WAIT to M_IDLE on dmem_data_ok.
- dstall = (M_IDLE & dmem_req & !dmem_data_ok) | (M_WAIT & !dmem_data_ok). A zero-wait access (ok in the issue cycle) causes no stall.

F FSM:
- F_IDLE to F_WAIT when imem_req & !imem_data_ok.
- F_WAIT to F_IDLE on imem_data_ok.
- Any state with a word still in flight goes to F_DISCARD when pc_redirect = 1.
- F_DISCARD to F_IDLE on imem_data_ok.
- fstall = imem busy (same form as dstall), or F_DISCARD.
- imem_discard = F_DISCARD & imem_data_ok.

Priority, highest first:
1. dstall:
   - fetch/decode/execute.stall = 1; memory.flush = 1.
   - pc_stall = 1; pc_redirect = 0.
   - A pending branch/jump is held and re-evaluated after release.
2. Load-use:
   - Condition: e_mem_to_reg & e_dst != 0 & ((d_uses_rs & e_dst == d_rs) | (d_uses_rt & e_dst == d_rt)).
   - Response: pc_stall = 1, fetch.stall = 1, decode.flush = 1, for exactly one cycle per hazard. d_jump is ignored that cycle.
3. e_branch_taken:
   - pc_redirect = 1; fetch.flush = 1; decode.flush = 1. This kills a jump in decode.
4. d_jump:
   - pc_redirect = 1; fetch.flush = 1.
5. fstall alone:
   - pc_stall = 1 unless pc_redirect; fetch.flush = 1. Other stages advance.

Forwarding, per operand x in {rs, rt}:
- 01 if m_reg_write & !m_mem_to_reg & m_dst != 0 & m_dst == e_x.
- else 10 if w_reg_write & w_dst != 0 & w_dst == e_x.
- else 00.
- The memory stage wins over writeback.

Counters:
- stall_cycles increments each cycle pc_stall = 1.
- flush_events increments each cycle pc_redirect = 1.
- Both saturate at all-ones.
- Reset mid-operation clears the FSMs immediately; an in-flight memory response after reset is not the unit's concern.

Decomposition:
- Add to the shared pipes package: fwd_sel_t enum (FWD_REG, FWD_MEM, FWD_WB), fetch_state_t (F_IDLE, F_WAIT, F_DISCARD), mem_state_t (M_IDLE, M_WAIT). Reuse the existing hazard_data_t and creg_addr_t.
- One natural combinational sub-module: hazard_forward, which computes fwd_rs/fwd_rt.

Test Plan:
- dmem_req = 1 with dmem_data_ok after 3 cycles:
  - fetch/decode/execute.stall = 1 and memory.flush = 1 for 3 cycles, then 0 on the ok cycle.
  - stall_cycles = 3.
- lw in execute (e_dst = 8, e_mem_to_reg = 1), decode d_rs = 8 with d_uses_rs = 1:
  - one cycle of pc_stall/fetch.stall/decode.flush.
  - Next cycle, with the load in memory, fwd_rs = 10 one cycle later (load in writeback).
- add in memory (m_dst = 3), add in writeback (w_dst = 3), e_rs = 3: fwd_rs = 01. Same case with m_dst = 0: fwd_rs = 10.
- e_branch_taken = 1 with d_jump = 1:
  - pc_redirect = 1, fetch.flush = decode.flush = 1.
  - flush_events increments by 1.
- Imem in flight (imem_req = 1, no ok) when the branch is taken:
  - F_DISCARD is entered.
  - When imem_data_ok arrives 2 cycles later: imem_discard = 1, fetch.flush = 1, then F_IDLE.
- dstall concurrent with e_branch_taken:
  - no redirect while stalled.
  - Redirect fires on the cycle dmem_data_ok = 1.
  - Assert resetn = 0 mid-M_WAIT: all outputs are 0 and the counters clear.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types: register addresses, per-stage stall/flush bundle, hazard FSM states.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] creg_addr_t;

    // One control pair per pipeline register: stall holds it, flush loads a bubble.
    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

    // Item X controls the register at the output of stage X.
    typedef struct packed {
        stage_ctrl_t fetch;
        stage_ctrl_t decode;
        stage_ctrl_t execute;
        stage_ctrl_t memory;
    } hazard_data_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        F_IDLE    = 2'b00,
        F_WAIT    = 2'b01,
        F_DISCARD = 2'b10
    } fetch_state_t;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

    // Memory-stage ALU result wins over writeback; loads in memory cannot forward yet.
    function automatic fwd_sel_t fwd_pick(
        input creg_addr_t src,
        input creg_addr_t m_dst,
        input logic       m_reg_write,
        input logic       m_mem_to_reg,
        input creg_addr_t w_dst,
        input logic       w_reg_write
    );
        if (m_reg_write && !m_mem_to_reg && (m_dst != '0) && (m_dst == src))
            return FWD_MEM;
        else if (w_reg_write && (w_dst != '0) && (w_dst == src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_forward.sv
// Execute-stage operand forwarding selects for rs and rt.
// Latency: purely combinational.
// Backpressure: none.
module hazard_ctrl_forward
    import hazard_ctrl_pkg::*;
(
    input  creg_addr_t e_rs_i,
    input  creg_addr_t e_rt_i,
    input  creg_addr_t m_dst_i,
    input  logic       m_reg_write_i,
    input  logic       m_mem_to_reg_i,
    input  creg_addr_t w_dst_i,
    input  logic       w_reg_write_i,
    output fwd_sel_t   fwd_rs_o,
    output fwd_sel_t   fwd_rt_o
);

    // Both operands use the same priority rule.
    always_comb begin
        fwd_rs_o = fwd_pick(e_rs_i, m_dst_i, m_reg_write_i, m_mem_to_reg_i, w_dst_i, w_reg_write_i);
        fwd_rt_o = fwd_pick(e_rt_i, m_dst_i, m_reg_write_i, m_mem_to_reg_i, w_dst_i, w_reg_write_i);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush, PC hold/redirect and forwarding control for the 5-stage MIPS pipeline.
// Latency: controls are combinational from inputs and FSM state; counters lag by one cycle.
// Backpressure: an outstanding dmem/imem access holds stages until its data_ok arrives.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             imem_req,
    input  logic             imem_data_ok,
    input  logic             dmem_req,
    input  logic             dmem_data_ok,
    input  creg_addr_t       d_rs,
    input  creg_addr_t       d_rt,
    input  logic             d_uses_rs,
    input  logic             d_uses_rt,
    input  logic             d_jump,
    input  creg_addr_t       e_rs,
    input  creg_addr_t       e_rt,
    input  creg_addr_t       e_dst,
    input  logic             e_reg_write,
    input  logic             e_mem_to_reg,
    input  logic             e_branch_taken,
    input  creg_addr_t       m_dst,
    input  logic             m_reg_write,
    input  logic             m_mem_to_reg,
    input  creg_addr_t       w_dst,
    input  logic             w_reg_write,
    output hazard_data_t     hazard,
    output logic             pc_stall,
    output logic             pc_redirect,
    output fwd_sel_t         fwd_rs,
    output fwd_sel_t         fwd_rt,
    output logic             imem_discard,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_t     f_state_q;
    mem_state_t       m_state_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             dstall, fbusy, fstall, load_use;
    hazard_data_t     hz_c;
    logic             pc_stall_c, pc_redirect_c;
    fwd_sel_t         fwd_rs_c, fwd_rt_c;

    // Load-use detection keys off mem_to_reg alone; reg_write is carried on the bus but not needed.
    logic unused_e_reg_write;
    assign unused_e_reg_write = e_reg_write;

    assign dstall = ((m_state_q == M_IDLE) && dmem_req && !dmem_data_ok)
                 || ((m_state_q == M_WAIT) && !dmem_data_ok);
    assign fbusy  = ((f_state_q == F_IDLE) && imem_req && !imem_data_ok)
                 || ((f_state_q == F_WAIT) && !imem_data_ok);
    assign fstall = fbusy || (f_state_q == F_DISCARD);

    assign load_use = e_mem_to_reg && (e_dst != '0)
                   && ((d_uses_rs && (e_dst == d_rs)) || (d_uses_rt && (e_dst == d_rt)));

    // Prioritised hazard resolution; fetch-wait only adds on top and never stalls+flushes together.
    always_comb begin
        hz_c          = '0;
        pc_stall_c    = 1'b0;
        pc_redirect_c = 1'b0;
        if (dstall) begin
            hz_c.fetch.stall   = 1'b1;
            hz_c.decode.stall  = 1'b1;
            hz_c.execute.stall = 1'b1;
            hz_c.memory.flush  = 1'b1;
            pc_stall_c         = 1'b1;
        end else if (load_use) begin
            pc_stall_c        = 1'b1;
            hz_c.fetch.stall  = 1'b1;
            hz_c.decode.flush = 1'b1;
        end else if (e_branch_taken) begin
            pc_redirect_c     = 1'b1;
            hz_c.fetch.flush  = 1'b1;
            hz_c.decode.flush = 1'b1;
        end else if (d_jump) begin
            pc_redirect_c    = 1'b1;
            hz_c.fetch.flush = 1'b1;
        end
        if (fstall && !dstall) begin
            if (!pc_redirect_c)
                pc_stall_c = 1'b1;
            if (!hz_c.fetch.stall)
                hz_c.fetch.flush = 1'b1;
        end
    end

    hazard_ctrl_forward u_forward (
        .e_rs_i         (e_rs),
        .e_rt_i         (e_rt),
        .m_dst_i        (m_dst),
        .m_reg_write_i  (m_reg_write),
        .m_mem_to_reg_i (m_mem_to_reg),
        .w_dst_i        (w_dst),
        .w_reg_write_i  (w_reg_write),
        .fwd_rs_o       (fwd_rs_c),
        .fwd_rt_o       (fwd_rt_c)
    );

    // Instruction- and data-memory handshake trackers; a redirect orphans any fetch in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f_state_q <= F_IDLE;
            m_state_q <= M_IDLE;
        end else begin
            case (m_state_q)
                M_IDLE:  if (dmem_req && !dmem_data_ok) m_state_q <= M_WAIT;
                M_WAIT:  if (dmem_data_ok) m_state_q <= M_IDLE;
                default: m_state_q <= M_IDLE;
            endcase
            case (f_state_q)
                F_IDLE:    if (imem_req && !imem_data_ok)
                               f_state_q <= pc_redirect_c ? F_DISCARD : F_WAIT;
                F_WAIT:    if (imem_data_ok)
                               f_state_q <= F_IDLE;
                           else if (pc_redirect_c)
                               f_state_q <= F_DISCARD;
                F_DISCARD: if (imem_data_ok) f_state_q <= F_IDLE;
                default:   f_state_q <= F_IDLE;
            endcase
        end
    end

    // Saturating performance counters: next-state values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall_c && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (pc_redirect_c && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // All control outputs read as zero while reset is held.
    assign hazard       = resetn ? hz_c : '0;
    assign pc_stall     = resetn && pc_stall_c;
    assign pc_redirect  = resetn && pc_redirect_c;
    assign fwd_rs       = resetn ? fwd_rs_c : FWD_REG;
    assign fwd_rt       = resetn ? fwd_rt_c : FWD_REG;
    assign imem_discard = resetn && (f_state_q == F_DISCARD) && imem_data_ok;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: scoreboard of expected control vectors per cycle.
// Latency: inputs driven 1ns after posedge, outputs sampled at negedge.
// Backpressure: memory waits emulated by holding data_ok low for chosen cycle counts.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, imem_req, imem_data_ok, dmem_req, dmem_data_ok;
    creg_addr_t d_rs, d_rt, e_rs, e_rt, e_dst, m_dst, w_dst;
    logic d_uses_rs, d_uses_rt, d_jump, e_reg_write, e_mem_to_reg, e_branch_taken;
    logic m_reg_write, m_mem_to_reg, w_reg_write;
    hazard_data_t hazard;
    logic pc_stall, pc_redirect, imem_discard;
    fwd_sel_t fwd_rs, fwd_rt;
    logic [CW-1:0] stall_cycles, flush_events;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn),
        .imem_req(imem_req), .imem_data_ok(imem_data_ok),
        .dmem_req(dmem_req), .dmem_data_ok(dmem_data_ok),
        .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .d_jump(d_jump),
        .e_rs(e_rs), .e_rt(e_rt), .e_dst(e_dst), .e_reg_write(e_reg_write),
        .e_mem_to_reg(e_mem_to_reg), .e_branch_taken(e_branch_taken),
        .m_dst(m_dst), .m_reg_write(m_reg_write), .m_mem_to_reg(m_mem_to_reg),
        .w_dst(w_dst), .w_reg_write(w_reg_write),
        .hazard(hazard), .pc_stall(pc_stall), .pc_redirect(pc_redirect),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .imem_discard(imem_discard),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    typedef struct packed {
        logic [7:0] hz;   // fetch{stall,flush}, decode, execute, memory
        logic       pcs;
        logic       pcr;
        logic [1:0] frs;
        logic [1:0] frt;
        logic       disc;
    } vec_t;

    localparam vec_t V_ZERO   = '0;
    localparam vec_t V_DSTALL = {8'b10_10_10_01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam vec_t V_LU     = {8'b10_01_00_00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam vec_t V_BR     = {8'b01_01_00_00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0};
    localparam vec_t V_JMP    = {8'b01_00_00_00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0};
    localparam vec_t V_FS     = {8'b01_00_00_00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam vec_t V_DISC   = {8'b01_00_00_00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1};

    vec_t sb[$];
    vec_t e, o;
    int n_vec = 0;
    int n_err = 0;
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_flush = '0;

    typedef struct packed {
        logic [4:0] rs, rt, md;
        logic       mw, mm;
        logic [4:0] wd;
        logic       ww;
        logic [1:0] frs, frt;
    } fv_t;

    fv_t ftbl [6] = '{
        {5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 2'b01, 2'b01},
        {5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 2'b10, 2'b10},
        {5'd3, 5'd5, 5'd3, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 2'b10},
        {5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b00, 2'b00},
        {5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 5'd3, 1'b0, 2'b00, 2'b00},
        {5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 2'b10, 2'b00}
    };

    function automatic vec_t observe();
        return {hazard, pc_stall, pc_redirect, fwd_rs, fwd_rt, imem_discard};
    endfunction

    task automatic idle();
        imem_req = 1'b0; imem_data_ok = 1'b0; dmem_req = 1'b0; dmem_data_ok = 1'b0;
        d_rs = '0; d_rt = '0; d_uses_rs = 1'b0; d_uses_rt = 1'b0; d_jump = 1'b0;
        e_rs = '0; e_rt = '0; e_dst = '0; e_reg_write = 1'b0; e_mem_to_reg = 1'b0;
        e_branch_taken = 1'b0; m_dst = '0; m_reg_write = 1'b0; m_mem_to_reg = 1'b0;
        w_dst = '0; w_reg_write = 1'b0;
    endtask

    // Push the expectation for the current inputs, advance the counter model, move to the sample edge.
    task automatic apply(input vec_t exp_v);
        sb.push_back(exp_v);
        if (resetn) begin
            if (exp_v.pcs && m_stall != '1) m_stall = m_stall + 1'b1;
            if (exp_v.pcr && m_flush != '1) m_flush = m_flush + 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        dmem_req = 1'b1; imem_req = 1'b1; e_branch_taken = 1'b1; d_jump = 1'b1;
        m_dst = 5'd3; m_reg_write = 1'b1; e_rs = 5'd3; w_dst = 5'd4; w_reg_write = 1'b1; e_rt = 5'd4;
        for (int i = 0; i < 2; i++) begin
            apply(V_ZERO);
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL reset c%0d: got %h want %h", i, o, e); end
            n_vec++;
            if (stall_cycles !== '0 || flush_events !== '0) begin
                n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cycles, flush_events);
            end
            @(posedge clk); #1;
        end
        idle();
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_dstall();
        for (int i = 0; i < 4; i++) begin
            dmem_req = 1'b1; dmem_data_ok = (i == 3);
            apply((i < 3) ? V_DSTALL : V_ZERO);
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL dstall c%0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
        idle();
        n_vec++;
        if (stall_cycles !== 4'd3) begin
            n_err++; $display("FAIL dstall_cnt: got %0d want 3", stall_cycles);
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 6; i++) begin
            idle();
            case (i)
                0: begin e_dst = 5'd8; e_mem_to_reg = 1'b1; e_reg_write = 1'b1;
                         d_rs = 5'd8; d_uses_rs = 1'b1; d_jump = 1'b1; end
                1: begin m_dst = 5'd8; m_reg_write = 1'b1; m_mem_to_reg = 1'b1;
                         e_rs = 5'd8; d_rs = 5'd8; d_uses_rs = 1'b1; end
                2: begin w_dst = 5'd8; w_reg_write = 1'b1; e_rs = 5'd8; end
                3: begin e_dst = 5'd9; e_mem_to_reg = 1'b1; d_rt = 5'd9; d_uses_rt = 1'b0; end
                4: begin e_dst = 5'd0; e_mem_to_reg = 1'b1; d_rs = 5'd0; d_uses_rs = 1'b1; end
                default: begin e_dst = 5'd9; e_mem_to_reg = 1'b1; d_rt = 5'd9; d_uses_rt = 1'b1; end
            endcase
            case (i)
                0, 5:    apply(V_LU);
                2:       apply({8'h00, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0});
                default: apply(V_ZERO);
            endcase
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL load_use c%0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
        idle();
        n_vec++;
        if (stall_cycles !== m_stall) begin
            n_err++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cycles, m_stall);
        end
    endtask

    task automatic test_forward();
        foreach (ftbl[i]) begin
            idle();
            e_rs = ftbl[i].rs; e_rt = ftbl[i].rt;
            m_dst = ftbl[i].md; m_reg_write = ftbl[i].mw; m_mem_to_reg = ftbl[i].mm;
            w_dst = ftbl[i].wd; w_reg_write = ftbl[i].ww;
            apply({8'h00, 1'b0, 1'b0, ftbl[i].frs, ftbl[i].frt, 1'b0});
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL forward v%0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
        idle();
    endtask

    task automatic test_branch();
        for (int i = 0; i < 2; i++) begin
            idle();
            e_branch_taken = (i == 0); d_jump = 1'b1;
            apply((i == 0) ? V_BR : V_JMP);
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL branch c%0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
            n_vec++;
            if (flush_events !== m_flush) begin
                n_err++; $display("FAIL branch_cnt c%0d: got %0d want %0d", i, flush_events, m_flush);
            end
        end
        idle();
    endtask

    task automatic test_discard();
        for (int i = 0; i < 5; i++) begin
            idle();
            imem_req = 1'b1;
            e_branch_taken = (i == 1);
            imem_data_ok = (i >= 3);
            case (i)
                1:       apply(V_BR);
                3:       apply(V_DISC);
                4:       apply(V_ZERO);
                default: apply(V_FS);
            endcase
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL discard c%0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
        idle();
        n_vec++;
        if (stall_cycles !== m_stall || flush_events !== m_flush) begin
            n_err++; $display("FAIL discard_cnt: got %0d/%0d want %0d/%0d",
                              stall_cycles, flush_events, m_stall, m_flush);
        end
    endtask

    task automatic test_dstall_branch();
        for (int i = 0; i < 3; i++) begin
            idle();
            dmem_req = 1'b1; e_branch_taken = 1'b1; dmem_data_ok = (i == 2);
            apply((i < 2) ? V_DSTALL : V_BR);
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL dstall_branch c%0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
        idle();
        n_vec++;
        if (flush_events !== m_flush) begin
            n_err++; $display("FAIL dstall_branch_cnt: got %0d want %0d", flush_events, m_flush);
        end
    endtask

    task automatic test_saturate_and_reset();
        for (int i = 0; i < 12; i++) begin
            idle();
            dmem_req = 1'b1;
            apply(V_DSTALL);
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL saturate c%0d: got %h want %h", i, o, e); end
            @(posedge clk); #1;
        end
        n_vec++;
        if (stall_cycles !== 4'hF) begin
            n_err++; $display("FAIL saturate_cnt: got %0d want 15", stall_cycles);
        end
        // Unit sits in M_WAIT; pull reset while the data access is still outstanding.
        resetn = 1'b0; e_branch_taken = 1'b1;
        m_stall = '0; m_flush = '0;
        apply(V_ZERO);
        e = sb.pop_front(); o = observe(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL mid_reset: got %h want %h", o, e); end
        n_vec++;
        if (stall_cycles !== '0 || flush_events !== '0) begin
            n_err++; $display("FAIL mid_reset_cnt: got %0d/%0d want 0/0", stall_cycles, flush_events);
        end
        @(posedge clk); #1;
        idle();
        resetn = 1'b1;
        apply(V_ZERO);
        e = sb.pop_front(); o = observe(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL post_reset: got %h want %h", o, e); end
        @(posedge clk); #1;
        n_vec++;
        if (stall_cycles !== '0) begin
            n_err++; $display("FAIL post_reset_cnt: got %0d want 0", stall_cycles);
        end
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        test_reset();
        test_dstall();
        test_load_use();
        test_forward();
        test_branch();
        test_discard();
        test_dstall_branch();
        test_saturate_and_reset();
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard: %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached want finish earlier", $time);
        $fatal(1);
    end

endmodule
